spu_evt_monitor: RTL and testbench
==================================

Name: spu_evt_monitor

Overview:
Receiving end of the SPU event interface driven by the core's event unit. Consumes the per-cycle event vector (e_id), the info word ({priv, asid}) and the source id (s_id). Filters events by privilege level and ASID and counts them per event line over a programmable cycle window. Raises a latched alert when any line's count reaches its threshold, and holds the alert until software acknowledges it.

Parameters:
ASID_WIDTH, 16, width of the ASID field in e_info; must be >= 1
NUM_EVT, 4, number of event lines, matching the e_id width
CNT_WIDTH, 16, width of each per-line event counter
WIN_WIDTH, 24, width of the window length and window timer

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
e_id_i  in  NUM_EVT  event pulses, one bit per line, sampled every cycle
e_info_i  in  2+ASID_WIDTH  {priv[1:0], asid}; priv encoding 01=M, 10=S, 11=U, 00=invalid
s_id_i  in  1  source id; only 0 (core) is counted
enable_i  in  1  monitor enable
priv_en_i  in  3  privilege filter: bit0=M, bit1=S, bit2=U
asid_match_en_i  in  1  1 = count only events whose asid equals asid_i
asid_i  in  ASID_WIDTH  ASID compare value
window_i  in  WIN_WIDTH  window length in cycles; 0 = do not start
thresh_i  in  NUM_EVT*CNT_WIDTH  per-line thresholds, line k at [k*CNT_WIDTH +: CNT_WIDTH]; 0 = line disabled
alert_ack_i  in  1  alert acknowledge pulse
alert_o  out  1  alert pending
alert_vec_o  out  NUM_EVT  lines that hit their threshold
cnt_o  out  NUM_EVT*CNT_WIDTH  live counter values
state_o  out  2  00=IDLE, 01=COUNT, 10=ALERT
ovf_o  out  NUM_EVT  sticky saturation flags (see Optional Feature)

Behaviour:
- Interface decision: one clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: state IDLE; all counters 0; window timer 0; alert_o 0; alert_vec_o 0; ovf_o 0. All outputs are registered.
- Qualify: q[k] = e_id_i[k] & s_id_i==0 & priv_en_i bit selected by priv & (!asid_match_en_i | asid==asid_i).
  - priv=00 never qualifies.
- IDLE -> COUNT: when enable_i=1 and window_i!=0.
  - On entry, clear counters and timer.
  - Latch window_i; later changes take effect only at the next window start.
- COUNT, every cycle:
  - cnt[k] += q[k], saturating at 2^CNT_WIDTH-1.
  - timer increments.
- Window end: the cycle with timer == latched_window-1. The event in that cycle is counted.
  - hit[k] = (thresh_i[k]!=0) & (cnt_next[k] >= thresh_i[k]). thresh_i is sampled live at this cycle.
  - If any hit: go to ALERT and load alert_vec_o=hit. alert_o rises the next cycle.
  - Otherwise, restart the window with no gap cycle: counters 0, timer 0, window_i re-latched.
- COUNT with enable_i=0: go to IDLE next cycle. Counters freeze and keep their values on cnt_o. enable_i has priority over a coincident window end; no alert is raised.
- ALERT:
  - Counting is frozen. alert_o=1 and alert_vec_o are held.
  - alert_ack_i is accepted only while alert_o=1. On ack: alert_o=0, alert_vec_o=0.
  - After ack, go to COUNT with a fresh window if enable_i=1 and window_i!=0; otherwise go to IDLE.
- An ack pulse while not in ALERT is ignored.
- An asynchronous reset mid-window or mid-alert returns everything to reset values immediately.
- Latency: event input to cnt_o = 1 cycle. Final window-end cycle to alert_o = 1 cycle.

Optional Feature:
SPU_EVT_OVF_STICKY_EN:
- Defined: ovf_o[k] sets when cnt[k] would exceed 2^CNT_WIDTH-1. It stays set until the next window start or reset. A set ovf_o[k] forces hit[k]=1 at window end if thresh_i[k]!=0.
- Not defined: ovf_o is tied to 0 and saturation does not affect hit.

Test Plan:
1. Reset with enable_i=1 and e_id_i=4'hF -> all outputs 0 while reset is low; after release, state_o=01 within 1 cycle.
2. window_i=10, thresh line0=3, priv_en_i=3'b001, e_info priv=01, e_id_i[0] pulsed 3 times (last one in cycle 9) -> alert_o=1 the cycle after the window end, alert_vec_o=4'b0001.
3. Same stimulus as scenario 2 but priv=11 (U) -> no count, no alert; window restarts with cnt_o=0 and no gap cycle.
4. asid_match_en_i=1, asid_i=5; events with asid 5 x2 and asid 7 x4; thresh=2, window=20 -> line0 count=2, alert raised.
5. Hold ALERT for 15 cycles with e_id_i=4'hF -> cnt_o unchanged. Ack with enable_i=1 -> alert_o=0, state_o=01, counters 0.
6. CNT_WIDTH=4, thresh=15, window=40, continuous events -> cnt_o saturates at 15 with no wrap. With SPU_EVT_OVF_STICKY_EN defined, ovf_o[0]=1; without it, ovf_o=0.

Source files
------------

// File: rtl/spu_evt_monitor.sv
// spu_evt_monitor: receiving end of the SPU event interface. Filters core
// events by privilege and ASID, counts them per line over a programmable
// cycle window, and raises a latched alert when a line reaches its threshold.
//
// Optional feature macro: SPU_EVT_OVF_STICKY_EN
//   defined   -> ovf_o[k] is a sticky saturation flag and forces hit[k]
//   undefined -> ovf_o is tied to 0
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   e_id_i                 per-line event pulses
//   e_info_i               {priv[1:0], asid}
//   s_id_i                 source id, only 0 is counted
//   enable_i               monitor enable
//   priv_en_i              privilege filter {U, S, M}
//   asid_match_en_i/asid_i ASID filter
//   window_i               window length in cycles (0 = do not start)
//   thresh_i               per-line thresholds (0 = line disabled)
//   alert_ack_i            alert acknowledge
//   alert_o, alert_vec_o   pending alert and lines that hit
//   cnt_o                  live counters
//   state_o                00 IDLE, 01 COUNT, 10 ALERT
//   ovf_o                  sticky saturation flags
module spu_evt_monitor #(
    parameter int ASID_WIDTH = 16,
    parameter int NUM_EVT    = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int WIN_WIDTH  = 24
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_EVT-1:0]             e_id_i,
    input  logic [ASID_WIDTH+1:0]          e_info_i,
    input  logic                           s_id_i,
    input  logic                           enable_i,
    input  logic [2:0]                     priv_en_i,
    input  logic                           asid_match_en_i,
    input  logic [ASID_WIDTH-1:0]          asid_i,
    input  logic [WIN_WIDTH-1:0]           window_i,
    input  logic [NUM_EVT*CNT_WIDTH-1:0]   thresh_i,
    input  logic                           alert_ack_i,
    output logic                           alert_o,
    output logic [NUM_EVT-1:0]             alert_vec_o,
    output logic [NUM_EVT*CNT_WIDTH-1:0]   cnt_o,
    output logic [1:0]                     state_o,
    output logic [NUM_EVT-1:0]             ovf_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        ALERT = 2'b10
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIN_WIDTH-1:0] WIN_ONE = {{(WIN_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_EVT];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_EVT];
    logic [WIN_WIDTH-1:0]   timer_q;
    logic [WIN_WIDTH-1:0]   win_q;
    logic                   alert_q;
    logic [NUM_EVT-1:0]     alert_vec_q;
    logic [NUM_EVT-1:0]     qual;
    logic [NUM_EVT-1:0]     hit;
    logic [1:0]             priv;
    logic [ASID_WIDTH-1:0]  asid;
    logic                   priv_ok;
    logic                   asid_ok;
    logic                   win_end;
    logic                   start_ok;
`ifdef SPU_EVT_OVF_STICKY_EN
    logic [NUM_EVT-1:0]     ovf_q;
    logic [NUM_EVT-1:0]     ovf_d;
`endif

    assign priv = e_info_i[ASID_WIDTH +: 2];
    assign asid = e_info_i[ASID_WIDTH-1:0];

    always_comb begin
        priv_ok = 1'b0;
        unique case (priv)
            2'b01:   priv_ok = priv_en_i[0];
            2'b10:   priv_ok = priv_en_i[1];
            2'b11:   priv_ok = priv_en_i[2];
            default: priv_ok = 1'b0;
        endcase
    end

    assign asid_ok  = !asid_match_en_i || (asid == asid_i);
    assign qual     = e_id_i & {NUM_EVT{priv_ok & asid_ok & !s_id_i}};
    // win_q is never 0 while counting, so win_q-1 cannot underflow.
    assign win_end  = (timer_q == (win_q - WIN_ONE));
    assign start_ok = enable_i && (window_i != '0);

    always_comb begin
`ifdef SPU_EVT_OVF_STICKY_EN
        ovf_d = ovf_q;
`endif
        hit = '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (qual[k]) begin
                if (cnt_q[k] != CNT_MAX) begin
                    cnt_d[k] = cnt_q[k] + CNT_ONE;
                end
`ifdef SPU_EVT_OVF_STICKY_EN
                else begin
                    ovf_d[k] = 1'b1;
                end
`endif
            end
            hit[k] = (thresh_i[k*CNT_WIDTH +: CNT_WIDTH] != '0) &&
                     ((cnt_d[k] >= thresh_i[k*CNT_WIDTH +: CNT_WIDTH])
`ifdef SPU_EVT_OVF_STICKY_EN
                      || ovf_d[k]
`endif
                     );
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            win_q       <= '0;
            alert_q     <= 1'b0;
            alert_vec_q <= '0;
            for (int k = 0; k < NUM_EVT; k++) cnt_q[k] <= '0;
`ifdef SPU_EVT_OVF_STICKY_EN
            ovf_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= COUNT;
                        timer_q <= '0;
                        win_q   <= window_i;
                        for (int k = 0; k < NUM_EVT; k++) cnt_q[k] <= '0;
`ifdef SPU_EVT_OVF_STICKY_EN
                        ovf_q   <= '0;
`endif
                    end
                end
                COUNT: begin
                    // Disable wins over a coincident window end; counters freeze.
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (win_end && (|hit)) begin
                        state_q     <= ALERT;
                        alert_q     <= 1'b1;
                        alert_vec_q <= hit;
                        for (int k = 0; k < NUM_EVT; k++) cnt_q[k] <= cnt_d[k];
`ifdef SPU_EVT_OVF_STICKY_EN
                        ovf_q       <= ovf_d;
`endif
                    end else if (win_end) begin
                        // Back-to-back window; a zero length stops the monitor.
                        state_q <= (window_i != '0) ? COUNT : IDLE;
                        timer_q <= '0;
                        win_q   <= window_i;
                        for (int k = 0; k < NUM_EVT; k++) cnt_q[k] <= '0;
`ifdef SPU_EVT_OVF_STICKY_EN
                        ovf_q   <= '0;
`endif
                    end else begin
                        timer_q <= timer_q + WIN_ONE;
                        for (int k = 0; k < NUM_EVT; k++) cnt_q[k] <= cnt_d[k];
`ifdef SPU_EVT_OVF_STICKY_EN
                        ovf_q   <= ovf_d;
`endif
                    end
                end
                ALERT: begin
                    if (alert_ack_i) begin
                        alert_q     <= 1'b0;
                        alert_vec_q <= '0;
                        if (start_ok) begin
                            state_q <= COUNT;
                            timer_q <= '0;
                            win_q   <= window_i;
                            for (int k = 0; k < NUM_EVT; k++) cnt_q[k] <= '0;
`ifdef SPU_EVT_OVF_STICKY_EN
                            ovf_q   <= '0;
`endif
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_EVT; k++) begin : g_cnt
        assign cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
    end

    assign alert_o     = alert_q;
    assign alert_vec_o = alert_vec_q;
    assign state_o     = state_q;
`ifdef SPU_EVT_OVF_STICKY_EN
    assign ovf_o       = ovf_q;
`else
    assign ovf_o       = '0;
`endif

endmodule

// File: tb/tb_spu_evt_monitor.sv
// tb_spu_evt_monitor: self-checking bench for spu_evt_monitor.
// Window results are queued when stimulus is planned and checked at window end.
module tb_spu_evt_monitor;

    localparam int AW = 16;
    localparam int NE = 4;
    localparam int CW = 4;
    localparam int WW = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NE-1:0]     e_id;
    logic [AW+1:0]     e_info;
    logic              s_id;
    logic              enable;
    logic [2:0]        priv_en;
    logic              asid_en;
    logic [AW-1:0]     asid;
    logic [WW-1:0]     window;
    logic [NE*CW-1:0]  thresh;
    logic              ack;
    logic              alert;
    logic [NE-1:0]     alert_vec;
    logic [NE*CW-1:0]  cnt;
    logic [1:0]        state;
    logic [NE-1:0]     ovf;

    always #5 clk = ~clk;

    spu_evt_monitor #(
        .ASID_WIDTH(AW), .NUM_EVT(NE), .CNT_WIDTH(CW), .WIN_WIDTH(WW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .e_id_i(e_id), .e_info_i(e_info),
        .s_id_i(s_id), .enable_i(enable), .priv_en_i(priv_en),
        .asid_match_en_i(asid_en), .asid_i(asid), .window_i(window),
        .thresh_i(thresh), .alert_ack_i(ack), .alert_o(alert),
        .alert_vec_o(alert_vec), .cnt_o(cnt), .state_o(state), .ovf_o(ovf)
    );

    typedef enum int {S_ALERT, S_VEC, S_CNT0, S_CNTV, S_STATE, S_OVF} sel_e;
    typedef struct {
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic          ev_a   [64];
    int            ok_a   [64];
    logic [1:0]    pv_a   [64];
    logic          sid_a  [64];
    logic [AW-1:0] asid_a [64];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            S_ALERT: return 32'(alert);
            S_VEC:   return 32'(alert_vec);
            S_CNT0:  return 32'(cnt[CW-1:0]);
            S_CNTV:  return 32'(cnt);
            S_STATE: return 32'(state);
            default: return 32'(ovf);
        endcase
    endfunction

    function automatic string sel_name(input sel_e s);
        case (s)
            S_ALERT: return "alert";
            S_VEC:   return "alert_vec";
            S_CNT0:  return "cnt0";
            S_CNTV:  return "cnt_vec";
            S_STATE: return "state";
            default: return "ovf";
        endcase
    endfunction

    function automatic int sat(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic sb_push(input sel_e s, input logic [31:0] v);
        exp_t e;
        e.sel = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(sel_name(e.sel), observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 64; i++) begin
            ev_a[i]   = 1'b0;
            ok_a[i]   = 0;
            pv_a[i]   = 2'b01;
            sid_a[i]  = 1'b0;
            asid_a[i] = '0;
        end
    endtask

    task automatic plan(input int c, input logic [1:0] pv, input logic sid,
                        input logic [AW-1:0] as, input int ok);
        ev_a[c]   = 1'b1;
        pv_a[c]   = pv;
        sid_a[c]  = sid;
        asid_a[c] = as;
        ok_a[c]   = ok;
    endtask

    // Entered right after the edge that started a window (timer = 0).
    task automatic run_win(input int win, input bit exp_alert);
        int run = 0;
        int total = 0;
        for (int c = 0; c < win; c++) total += ok_a[c];
        if (exp_alert) begin
            sb_push(S_ALERT, 1);
            sb_push(S_VEC, 32'h1);
            sb_push(S_CNT0, 32'(sat(total)));
            sb_push(S_STATE, 2);
`ifdef SPU_EVT_OVF_STICKY_EN
            sb_push(S_OVF, (total > 15) ? 32'h1 : 32'h0);
`else
            sb_push(S_OVF, 0);
`endif
        end else begin
            sb_push(S_ALERT, 0);
            sb_push(S_VEC, 0);
            sb_push(S_CNT0, 0);
            sb_push(S_STATE, 1);
            sb_push(S_OVF, 0);
        end
        for (int c = 0; c < win; c++) begin
            e_id   = {3'b000, ev_a[c]};
            e_info = {pv_a[c], asid_a[c]};
            s_id   = sid_a[c];
            tick();
            run += ok_a[c];
            if (c < win - 1) begin
                check("cnt_run", observe(S_CNT0), 32'(sat(run)));
                check("alert_early", observe(S_ALERT), 0);
            end
        end
        e_id   = '0;
        e_info = {2'b01, 16'h0};
        s_id   = 1'b0;
        sb_drain();
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        e_id    = 4'hF;
        e_info  = {2'b01, 16'h0};
        s_id    = 1'b0;
        priv_en = 3'b001;
        asid_en = 1'b0;
        asid    = '0;
        window  = 24'd10;
        thresh  = 16'h0003;
        ack     = 1'b0;

        // Reset held with activity on the inputs
        repeat (3) tick();
        check("rst_alert", observe(S_ALERT), 0);
        check("rst_vec", observe(S_VEC), 0);
        check("rst_cnt", observe(S_CNTV), 0);
        check("rst_state", observe(S_STATE), 0);
        check("rst_ovf", observe(S_OVF), 0);
        rst_n = 1'b1;
        tick();
        check("start_state", observe(S_STATE), 1);
        enable = 1'b0;
        e_id   = '0;
        tick();
        check("idle_state", observe(S_STATE), 0);

        // M-mode events reach the threshold at the last window cycle
        enable = 1'b1;
        tick();
        check("win_start", observe(S_STATE), 1);
        clear_plan();
        plan(2, 2'b01, 1'b0, 16'h0, 1);
        plan(5, 2'b01, 1'b0, 16'h0, 1);
        plan(9, 2'b01, 1'b0, 16'h0, 1);
        run_win(10, 1'b1);

        // Alert holds counters frozen against further events
        e_id = 4'hF;
        repeat (15) tick();
        e_id = '0;
        sb_push(S_CNTV, 32'h0003);
        sb_push(S_ALERT, 1);
        sb_push(S_STATE, 2);
        sb_drain();
        pulse_ack();
        sb_push(S_ALERT, 0);
        sb_push(S_VEC, 0);
        sb_push(S_STATE, 1);
        sb_push(S_CNTV, 0);
        sb_drain();

        // Filtered events never count; window restarts with no gap
        clear_plan();
        plan(2, 2'b11, 1'b0, 16'h0, 0);
        plan(5, 2'b11, 1'b0, 16'h0, 0);
        plan(7, 2'b01, 1'b1, 16'h0, 0);
        plan(9, 2'b00, 1'b0, 16'h0, 0);
        run_win(10, 1'b0);
        clear_plan();
        plan(0, 2'b01, 1'b0, 16'h0, 1);
        plan(4, 2'b01, 1'b0, 16'h0, 1);
        plan(9, 2'b01, 1'b0, 16'h0, 1);
        run_win(10, 1'b1);

        // ASID filtering
        asid_en = 1'b1;
        asid    = 16'd5;
        thresh  = 16'h0002;
        window  = 24'd20;
        pulse_ack();
        clear_plan();
        plan(1, 2'b01, 1'b0, 16'd5, 1);
        plan(3, 2'b01, 1'b0, 16'd5, 1);
        plan(5, 2'b01, 1'b0, 16'd7, 0);
        plan(7, 2'b01, 1'b0, 16'd7, 0);
        plan(9, 2'b01, 1'b0, 16'd7, 0);
        plan(11, 2'b01, 1'b0, 16'd7, 0);
        run_win(20, 1'b1);

        // Disable coincident with window end suppresses the alert
        asid_en = 1'b0;
        thresh  = 16'h0001;
        window  = 24'd4;
        pulse_ack();
        e_id = 4'h1;
        repeat (2) tick();
        e_id = '0;
        tick();
        enable = 1'b0;
        tick();
        sb_push(S_STATE, 0);
        sb_push(S_ALERT, 0);
        sb_push(S_VEC, 0);
        sb_push(S_CNT0, 2);
        sb_drain();
        pulse_ack();
        repeat (2) tick();
        check("idle_ack_state", observe(S_STATE), 0);
        check("idle_ack_alert", observe(S_ALERT), 0);
        check("idle_cnt_hold", observe(S_CNT0), 2);

        // Saturation at the 4-bit counter limit
        thresh = 16'h000F;
        window = 24'd40;
        enable = 1'b1;
        tick();
        clear_plan();
        for (int c = 0; c < 40; c++) plan(c, 2'b01, 1'b0, 16'h0, 1);
        run_win(40, 1'b1);

        // Asynchronous reset in the middle of an alert
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_alert", observe(S_ALERT), 0);
        check("arst_state", observe(S_STATE), 0);
        check("arst_cnt", observe(S_CNTV), 0);
        check("arst_vec", observe(S_VEC), 0);
        check("arst_ovf", observe(S_OVF), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
